// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encodings, special display nibbles and
// the SS.CC display formatter.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    // Nibble codes the 7-segment driver renders as symbols rather than digits.
    localparam logic [3:0] SEG_DASH  = 4'hA;
    localparam logic [3:0] SEG_BLANK = 4'hB;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    function automatic logic [15:0] fmt_display(input logic [15:0] bcd, input bit blank_lz);
        logic [15:0] r;
        r = bcd;
        if (blank_lz && (bcd[15:12] == 4'd0))
            r[15:12] = SEG_BLANK;
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit_cnt.sv
// One BCD decade (0..9) with carry-out; four of these chain into the SS.CC count.
module bcd_digit_cnt (
    input  logic       clk,
    input  logic       clr,
    input  logic       clr_sync,
    input  logic       en,
    output logic [3:0] q,
    output logic       carry
);

    assign carry = en & (q == 4'd9);

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            q <= 4'd0;
        else if (clr_sync)
            q <= 4'd0;
        else if (en)
            q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
    end

endmodule

// File: rtl/stopwatch_core.sv
// SS.CC stopwatch: button synchronizers, centisecond prescaler, run/lap/stop FSM
// and the registered display word for the 4-digit 7-segment driver.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   ST_IDLE | cleared, waiting for start
//   ST_RUN  | counting, display shows live count
//   ST_LAP  | counting, display frozen on captured lap value
//   ST_STOP | halted, count and prescaler fraction held
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    output logic [15:0] x,
    output logic        running,
    output logic        frozen
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_t state_q, state_d;

    logic [2:0]    ss_sync, lap_sync;
    logic          ss_p, lap_p;
    logic [PW-1:0] pre_cnt;
    logic          tick, at_max, ovf, cnt_en;
    logic          clear_all, lap_load;
    logic [3:0]    dig   [4];
    logic [3:0]    carry;
    logic [3:0]    dig_en;
    logic [15:0]   count, lap_reg;

    // Two synchronizer stages, a third for edge history, then a registered pulse.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ss_sync  <= 3'b000;
            lap_sync <= 3'b000;
            ss_p     <= 1'b0;
            lap_p    <= 1'b0;
        end else begin
            ss_sync  <= {ss_sync[1:0], btn_start_stop};
            lap_sync <= {lap_sync[1:0], btn_lap};
            ss_p     <= ss_sync[1] & ~ss_sync[2];
            lap_p    <= lap_sync[1] & ~lap_sync[2];
        end
    end

    assign running = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign frozen  = (state_q == ST_LAP);

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            pre_cnt <= '0;
        else if (clear_all)
            pre_cnt <= '0;
        else if (running)
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
    end

    assign tick   = running && (pre_cnt == PRE_LAST);
    assign count  = {dig[3], dig[2], dig[1], dig[0]};
    assign at_max = (count == BCD_MAX);
    assign cnt_en = tick & ~at_max;
    // carry[3] can only fire on a would-be wrap, which at_max already blocks.
    assign ovf    = (tick & at_max) | carry[3];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign dig_en[gi] = cnt_en;
            end else begin : g_upper
                assign dig_en[gi] = carry[gi-1];
            end
            bcd_digit_cnt u_digit (
                .clk      (clk),
                .clr      (clr),
                .clr_sync (clear_all),
                .en       (dig_en[gi]),
                .q        (dig[gi]),
                .carry    (carry[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        clear_all = 1'b0;
        lap_load  = 1'b0;
        if (ovf) begin
            state_d = ST_STOP;
        end else begin
            case (state_q)
                ST_IDLE: if (ss_p) state_d = ST_RUN;
                ST_RUN: begin
                    if (ss_p) begin
                        state_d = ST_STOP;
                    end else if (lap_p) begin
                        state_d  = ST_LAP;
                        lap_load = 1'b1;
                    end
                end
                ST_LAP: begin
                    if (ss_p)
                        state_d = ST_STOP;
                    else if (lap_p)
                        state_d = ST_RUN;
                end
                ST_STOP: begin
                    if (ss_p) begin
                        state_d = ST_RUN;
                    end else if (lap_p) begin
                        state_d   = ST_IDLE;
                        clear_all = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            lap_reg <= '0;
        else if (clear_all)
            lap_reg <= '0;
        else if (lap_load)
            lap_reg <= count;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            x <= fmt_display(16'h0000, BLANK_LZ);
        else
            x <= fmt_display((state_q == ST_LAP) ? lap_reg : count, BLANK_LZ);
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Stopwatch bench: directed scenarios plus random button activity, checked every
// cycle against an integer-centisecond reference model.
module tb_stopwatch_core;

    localparam int TD = 4;
    localparam bit BL = 1'b1;
    localparam int S_IDLE = 0, S_RUN = 1, S_LAP = 2, S_STOP = 3;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        btn_ss = 1'b0;
    logic        btn_lp = 1'b0;
    logic [15:0] x;
    logic        running, frozen;

    always #5 clk = ~clk;

    stopwatch_core #(.TICK_DIV(TD), .BLANK_LZ(BL)) dut (
        .clk            (clk),
        .clr            (clr),
        .btn_start_stop (btn_ss),
        .btn_lap        (btn_lp),
        .x              (x),
        .running        (running),
        .frozen         (frozen)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: time kept as an integer number of centiseconds.
    int          m_st, m_cs, m_pre, m_lap;
    logic [15:0] m_x;
    bit   [2:0]  hist_ss, hist_lp;
    bit          pend_ss, pend_lp;

    function automatic logic [15:0] disp(input int v);
        int a, b, c, d;
        logic [3:0] n3;
        a  = v / 1000;
        b  = (v / 100) % 10;
        c  = (v / 10) % 10;
        d  = v % 10;
        n3 = a[3:0];
        if (BL && a == 0) n3 = 4'hB;
        return {n3, b[3:0], c[3:0], d[3:0]};
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_cs = 0; m_pre = 0; m_lap = 0;
        m_x = disp(0);
        hist_ss = '0; hist_lp = '0; pend_ss = 0; pend_lp = 0;
    endtask

    task automatic model_step();
        bit ssp, lpp, tk, ov;
        int cs_old;
        ssp = pend_ss;
        lpp = pend_lp;
        // a press acts three samples after the level is first seen high
        pend_ss = hist_ss[1] & ~hist_ss[2];
        pend_lp = hist_lp[1] & ~hist_lp[2];
        hist_ss = {hist_ss[1:0], btn_ss};
        hist_lp = {hist_lp[1:0], btn_lp};
        m_x = disp((m_st == S_LAP) ? m_lap : m_cs);
        tk = 0;
        if (m_st == S_RUN || m_st == S_LAP) begin
            tk = (m_pre == TD - 1);
            m_pre = (m_pre + 1) % TD;
        end
        ov = tk && (m_cs == 9999);
        cs_old = m_cs;
        if (tk && !ov) m_cs++;
        if (ov) m_st = S_STOP;
        else if (ssp) m_st = (m_st == S_IDLE || m_st == S_STOP) ? S_RUN : S_STOP;
        else if (lpp) begin
            case (m_st)
                S_RUN:  begin m_st = S_LAP; m_lap = cs_old; end
                S_LAP:  m_st = S_RUN;
                S_STOP: begin m_st = S_IDLE; m_cs = 0; m_pre = 0; m_lap = 0; end
                default: ;
            endcase
        end
    endtask

    task automatic check_outs();
        chk("x", 32'(x), 32'(m_x));
        chk("running", 32'(running), 32'(m_st == S_RUN || m_st == S_LAP));
        chk("frozen", 32'(frozen), 32'(m_st == S_LAP));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (clr) model_reset();
        else     model_step();
        check_outs();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic press(input bit lap, input int hold);
        if (lap) btn_lp = 1'b1;
        else     btn_ss = 1'b1;
        cycles(hold);
        btn_ss = 1'b0;
        btn_lp = 1'b0;
        cycles(4);
    endtask

    task automatic wait_cs(input int target, input int budget);
        for (int i = 0; i < budget && m_cs != target; i++) cyc();
        chk("wait_cs", 32'(m_cs), 32'(target));
    endtask

    initial begin
        model_reset();
        // 1: reset and idle
        cycles(3);
        #2 clr = 1'b0;
        chk("rst_x", 32'(x), 32'h0000_B000);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_frozen", 32'(frozen), 32'd0);
        cycles(50);
        chk("idle_x", 32'(x), 32'h0000_B000);

        // 2: start latency and 01.23
        btn_ss = 1'b1;
        cycles(3);
        chk("start_lat3", 32'(running), 32'd0);
        cycles(1);
        chk("start_lat4", 32'(running), 32'd1);
        cycles(100);
        btn_ss = 1'b0;
        cycles(393);
        chk("run_0123", 32'(x), 32'h0000_B123);

        // 3: lap freeze and release
        wait_cs(500, 3000);
        press(1'b1, 3);
        cycles(40);
        chk("lap_frozen", 32'(frozen), 32'd1);
        chk("lap_hold", 32'(x), 32'h0000_B500);
        press(1'b1, 2);
        cycles(5);
        chk("lap_release", 32'(frozen), 32'd0);

        // 4: stop, resume, stop, clear
        press(1'b0, 2);
        cycles(200);
        press(1'b0, 2);
        cycles(80);
        press(1'b0, 2);
        press(1'b1, 2);
        cycles(2);
        chk("clear_x", 32'(x), 32'h0000_B000);
        chk("clear_running", 32'(running), 32'd0);

        // 5: overflow holds at 99.99, then simultaneous presses from RUN
        press(1'b0, 2);
        for (int i = 0; i < 41000 && running; i++) cyc();
        chk("ovf_running", 32'(running), 32'd0);
        chk("ovf_x", 32'(x), 32'h0000_9999);
        cycles(50);
        chk("ovf_hold", 32'(x), 32'h0000_9999);
        press(1'b1, 2);
        press(1'b0, 2);
        cycles(20);
        btn_ss = 1'b1;
        btn_lp = 1'b1;
        cycles(6);
        chk("simul_running", 32'(running), 32'd0);
        chk("simul_frozen", 32'(frozen), 32'd0);
        btn_ss = 1'b0;
        btn_lp = 1'b0;
        cycles(4);

        // 6: async clear while in LAP, restart from 00.00
        press(1'b1, 2);
        press(1'b0, 2);
        cycles(10);
        press(1'b1, 2);
        cycles(3);
        chk("pre_rst_frozen", 32'(frozen), 32'd1);
        #3 clr = 1'b1;
        #1;
        model_reset();
        chk("arst_x", 32'(x), 32'h0000_B000);
        chk("arst_running", 32'(running), 32'd0);
        chk("arst_frozen", 32'(frozen), 32'd0);
        cycles(2);
        #2 clr = 1'b0;
        press(1'b0, 2);
        cycles(20);
        chk("restart_x", 32'(x), 32'h0000_B005);

        // random button activity
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) btn_ss = ~btn_ss;
            if ($urandom_range(0, 29) == 0) btn_lp = ~btn_lp;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
